// File: rtl/mem_port_arbiter.sv
// Arbitrates one outstanding fetch/data access onto a single memory bus; data wins ties, with an optional fetch starvation guard (ARB_STARVE_GUARD_EN).
// Latency: req seen in IDLE -> mem_req next cycle; ack -> *_ready next cycle. Requesters stall until their ready pulse.
module mem_port_arbiter #(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned ALEN         = 32,
    parameter int unsigned TIMEOUT_CYC  = 255,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_req,
    input  logic [ALEN-1:0] if_addr,
    output logic            if_ready,
    output logic [XLEN-1:0] if_rdata,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [ALEN-1:0] d_addr,
    input  logic [XLEN-1:0] d_wdata,
    input  logic [3:0]      d_be,
    output logic            d_ready,
    output logic [XLEN-1:0] d_rdata,
    output logic            mem_req,
    output logic            mem_we,
    output logic [ALEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [3:0]      mem_be,
    input  logic            mem_ack,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            bus_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2,
        RESP  = 2'd3
    } state_t;

    // Counter compares against the last cycle index so mem_req stays high for exactly TIMEOUT_CYC cycles.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYC - 1);

    if (TIMEOUT_CYC == 0 || TIMEOUT_CYC > 255 || STARVE_LIMIT > 255) begin : g_bad_cfg
        $error("mem_port_arbiter: TIMEOUT_CYC must be 1..255 and STARVE_LIMIT at most 255");
    end

    state_t          state_q, state_d;
    logic            mem_req_q, mem_req_d;
    logic            mem_we_q, mem_we_d;
    logic [ALEN-1:0] mem_addr_q, mem_addr_d;
    logic [XLEN-1:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]      mem_be_q, mem_be_d;
    logic [7:0]      tmo_q, tmo_d;
    logic            if_ready_q, if_ready_d;
    logic            d_ready_q, d_ready_d;
    logic [XLEN-1:0] if_rdata_q, if_rdata_d;
    logic [XLEN-1:0] d_rdata_q, d_rdata_d;
    logic            bus_err_q, bus_err_d;

    logic            starve_w;
    logic            grant_d_w;
    logic            grant_i_w;

    assign grant_d_w = (state_q == IDLE) && d_req && !starve_w;
    assign grant_i_w = (state_q == IDLE) && if_req && !grant_d_w;

`ifdef ARB_STARVE_GUARD_EN
    localparam logic [7:0] STREAK_MAX = 8'(STARVE_LIMIT);

    logic [7:0] streak_q, streak_d;

    assign starve_w = if_req && (streak_q == STREAK_MAX);

    // Streak counts data grants that overtook a waiting fetch.
    always_comb begin
        streak_d = streak_q;
        if (grant_i_w) begin
            streak_d = 8'd0;
        end else if (grant_d_w) begin
            if (!if_req) begin
                streak_d = 8'd0;
            end else if (streak_q != 8'hFF) begin
                streak_d = streak_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            streak_q <= 8'd0;
        end else begin
            streak_q <= streak_d;
        end
    end
`else
    assign starve_w = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        tmo_d       = tmo_q;
        if_ready_d  = 1'b0;
        d_ready_d   = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        bus_err_d   = bus_err_q;

        case (state_q)
            IDLE: begin
                if (grant_d_w) begin
                    state_d     = GNT_D;
                    mem_req_d   = 1'b1;
                    mem_we_d    = d_we;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                    mem_be_d    = d_be;
                    tmo_d       = 8'd0;
                end else if (grant_i_w) begin
                    state_d     = GNT_I;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = if_addr;
                    mem_wdata_d = '0;
                    mem_be_d    = 4'hF;
                    tmo_d       = 8'd0;
                end
            end

            GNT_I, GNT_D: begin
                if (mem_ack) begin
                    state_d   = RESP;
                    mem_req_d = 1'b0;
                    if (state_q == GNT_I) begin
                        if_rdata_d = mem_rdata;
                        if_ready_d = 1'b1;
                    end else begin
                        d_rdata_d = mem_we_q ? '0 : mem_rdata;
                        d_ready_d = 1'b1;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    // Abort still answers the requester so the CPU never deadlocks.
                    state_d   = RESP;
                    mem_req_d = 1'b0;
                    bus_err_d = 1'b1;
                    if (state_q == GNT_I) begin
                        if_rdata_d = '0;
                        if_ready_d = 1'b1;
                    end else begin
                        d_rdata_d = '0;
                        d_ready_d = 1'b1;
                    end
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end

            RESP: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= 4'h0;
            tmo_q       <= 8'd0;
            if_ready_q  <= 1'b0;
            d_ready_q   <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            tmo_q       <= tmo_d;
            if_ready_q  <= if_ready_d;
            d_ready_q   <= d_ready_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            bus_err_q   <= bus_err_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_be    = mem_be_q;
    assign if_ready  = if_ready_q;
    assign if_rdata  = if_rdata_q;
    assign d_ready   = d_ready_q;
    assign d_rdata   = d_rdata_q;
    assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch, tie, timeout, stray ack, reset mid-access, starvation.
// Inputs driven and outputs checked 1 time unit after the rising edge; memory model runs on the falling edge.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ready;
    logic [31:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_be;
    logic        d_ready;
    logic [31:0] d_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] ack_data;
    logic        bus_err;

    logic        ack_resp;
    logic        ack_force;
    int          ack_dly;
    int          req_cyc;
    logic        prev_req;
    int          n_if_rdy;
    int          n_d_rdy;
    logic [31:0] g_addr[$];
    logic        g_we[$];
    logic [31:0] g_wdata[$];

    int          n_cmp = 0;
    int          n_bad = 0;

    assign mem_ack = ack_resp | ack_force;

    mem_port_arbiter #(
        .XLEN(32), .ALEN(32), .TIMEOUT_CYC(8), .STARVE_LIMIT(4)
    ) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_ready(d_ready), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(ack_data), .bus_err(bus_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // sel: 0 = mem_req, 1 = if_ready, 2 = d_ready. Returns edges waited.
    task automatic wait_for(input string tag, input int sel, input int limit, output int cyc);
        logic s;
        cyc = 0;
        s   = 1'b0;
        while (!s && cyc < limit) begin
            @(posedge clk);
            #1;
            cyc++;
            case (sel)
                0:       s = mem_req;
                1:       s = if_ready;
                default: s = d_ready;
            endcase
        end
        if (!s) chk({tag, "_timeout"}, 32'(s), 32'd1);
    endtask

    task automatic clear_mon();
        n_if_rdy = 0;
        n_d_rdy  = 0;
        g_addr.delete();
        g_we.delete();
        g_wdata.delete();
    endtask

    // Memory responder and monitor: ack ack_dly cycles after mem_req rises (-1 = never).
    initial begin
        ack_resp = 1'b0;
        req_cyc  = 0;
        prev_req = 1'b0;
        n_if_rdy = 0;
        n_d_rdy  = 0;
        forever begin
            @(negedge clk);
            if (mem_req) begin
                ack_resp = (ack_dly >= 0) && (req_cyc == ack_dly);
                req_cyc++;
            end else begin
                ack_resp = 1'b0;
                req_cyc  = 0;
            end
            if (mem_req && !prev_req) begin
                g_addr.push_back(mem_addr);
                g_we.push_back(mem_we);
                g_wdata.push_back(mem_wdata);
            end
            prev_req = mem_req;
            if (if_ready) n_if_rdy++;
            if (d_ready)  n_d_rdy++;
        end
    end

    initial begin
        int          cyc;
        int          n;
        logic [31:0] exp_g [6];

        rst       = 1'b0;
        if_req    = 1'b0;
        if_addr   = '0;
        d_req     = 1'b0;
        d_we      = 1'b0;
        d_addr    = '0;
        d_wdata   = '0;
        d_be      = 4'h0;
        ack_force = 1'b0;
        ack_dly   = -1;
        ack_data  = '0;

        // Reset state
        step(3);
        chk("rst_mem_req",  32'(mem_req),  32'd0);
        chk("rst_mem_we",   32'(mem_we),   32'd0);
        chk("rst_mem_addr", mem_addr,      32'd0);
        chk("rst_mem_be",   32'(mem_be),   32'd0);
        chk("rst_if_ready", 32'(if_ready), 32'd0);
        chk("rst_d_ready",  32'(d_ready),  32'd0);
        chk("rst_if_rdata", if_rdata,      32'd0);
        chk("rst_bus_err",  32'(bus_err),  32'd0);
        rst = 1'b1;
        step(2);

        // Fetch only, ack 2 cycles after mem_req
        clear_mon();
        ack_dly  = 2;
        ack_data = 32'h0000_0013;
        if_addr  = 32'h100;
        if_req   = 1'b1;
        wait_for("t1_req", 0, 10, cyc);
        chk("t1_req_lat",  32'(cyc),    32'd1);
        chk("t1_mem_addr", mem_addr,    32'h100);
        chk("t1_mem_be",   32'(mem_be), 32'hF);
        chk("t1_mem_we",   32'(mem_we), 32'd0);
        wait_for("t1_rdy", 1, 20, cyc);
        chk("t1_rdy_lat",  32'(cyc),    32'd3);
        chk("t1_if_rdata", if_rdata,    32'h0000_0013);
        if_req = 1'b0;
        step(1);
        chk("t1_pulse_end", 32'(if_ready), 32'd0);
        step(4);
        chk("t1_if_rdy_cnt", 32'(n_if_rdy), 32'd1);

        // Tie: store and fetch together, data first
        clear_mon();
        ack_dly  = 1;
        ack_data = 32'h0000_0055;
        d_we     = 1'b1;
        d_addr   = 32'h200;
        d_wdata  = 32'hDEAD_BEEF;
        d_be     = 4'hF;
        d_req    = 1'b1;
        if_addr  = 32'h104;
        if_req   = 1'b1;
        wait_for("t2_drdy", 2, 30, cyc);
        d_req = 1'b0;
        d_we  = 1'b0;
        chk("t2_store_rdata", d_rdata, 32'd0);
        wait_for("t2_irdy", 1, 30, cyc);
        if_req = 1'b0;
        chk("t2_if_rdata", if_rdata, 32'h0000_0055);
        step(3);
        chk("t2_n_grants",  32'(g_addr.size()), 32'd2);
        chk("t2_g0_addr",   g_addr[0],          32'h200);
        chk("t2_g0_we",     32'(g_we[0]),       32'd1);
        chk("t2_g0_wdata",  g_wdata[0],         32'hDEAD_BEEF);
        chk("t2_g1_addr",   g_addr[1],          32'h104);
        chk("t2_g1_we",     32'(g_we[1]),       32'd0);
        chk("t2_d_rdy_cnt", 32'(n_d_rdy),       32'd1);
        chk("t2_i_rdy_cnt", 32'(n_if_rdy),      32'd1);

        // Load with data, then timeout on a load
        ack_dly  = 0;
        ack_data = 32'hA5A5_A5A5;
        d_addr   = 32'h304;
        d_be     = 4'h3;
        d_req    = 1'b1;
        wait_for("t3_load", 2, 20, cyc);
        d_req = 1'b0;
        chk("t3_load_rdata", d_rdata,      32'hA5A5_A5A5);
        chk("t3_err_before", 32'(bus_err), 32'd0);
        step(2);
        clear_mon();
        ack_dly = -1;
        d_addr  = 32'h300;
        d_req   = 1'b1;
        wait_for("t3_req", 0, 10, cyc);
        n = 1;
        for (int i = 0; i < 40 && mem_req; i++) begin
            step(1);
            if (mem_req) n++;
        end
        chk("t3_req_cycles", 32'(n),       32'd8);
        chk("t3_abort_rdy",  32'(d_ready), 32'd1);
        chk("t3_abort_data", d_rdata,      32'd0);
        chk("t3_bus_err",    32'(bus_err), 32'd1);
        d_req = 1'b0;
        step(4);
        chk("t3_err_sticky", 32'(bus_err), 32'd1);
        chk("t3_d_rdy_cnt",  32'(n_d_rdy), 32'd1);

        // Stray ack while idle
        clear_mon();
        ack_force = 1'b1;
        step(2);
        ack_force = 1'b0;
        step(2);
        chk("t6_no_if_rdy", 32'(n_if_rdy), 32'd0);
        chk("t6_no_d_rdy",  32'(n_d_rdy),  32'd0);
        chk("t6_mem_req",   32'(mem_req),  32'd0);
        ack_dly  = 0;
        ack_data = 32'h0000_1234;
        if_addr  = 32'h110;
        if_req   = 1'b1;
        wait_for("t6_req", 0, 10, cyc);
        chk("t6_req_lat", 32'(cyc), 32'd1);
        wait_for("t6_rdy", 1, 20, cyc);
        if_req = 1'b0;
        chk("t6_if_rdata", if_rdata, 32'h0000_1234);
        step(2);

        // Reset in the middle of a data access
        clear_mon();
        ack_dly = -1;
        d_addr  = 32'h400;
        d_we    = 1'b0;
        d_req   = 1'b1;
        wait_for("t5_req", 0, 10, cyc);
        step(2);
        rst   = 1'b0;
        d_req = 1'b0;
        step(1);
        chk("t5_mem_req", 32'(mem_req), 32'd0);
        chk("t5_bus_err", 32'(bus_err), 32'd0);
        chk("t5_d_ready", 32'(d_ready), 32'd0);
        rst = 1'b1;
        step(12);
        chk("t5_no_d_rdy", 32'(n_d_rdy), 32'd0);
        ack_dly  = 1;
        ack_data = 32'h0000_0077;
        if_addr  = 32'h108;
        if_req   = 1'b1;
        wait_for("t5_freq", 0, 10, cyc);
        chk("t5_req_lat", 32'(cyc), 32'd1);
        wait_for("t5_frdy", 1, 20, cyc);
        if_req = 1'b0;
        chk("t5_if_rdata", if_rdata,      32'h0000_0077);
        chk("t5_err_clr",  32'(bus_err),  32'd0);
        step(2);

        // Starvation: both requests held, 1-cycle memory
        clear_mon();
        ack_dly  = 0;
        ack_data = 32'd0;
        d_we     = 1'b0;
        d_addr   = 32'h500;
        if_addr  = 32'h10C;
        d_req    = 1'b1;
        if_req   = 1'b1;
        for (int i = 0; i < 200 && g_addr.size() < 6; i++) step(1);
        chk("t4_six_grants", 32'(g_addr.size() >= 6), 32'd1);
        d_req  = 1'b0;
        if_req = 1'b0;
        step(6);
        for (int i = 0; i < 6; i++) exp_g[i] = 32'h500;
`ifdef ARB_STARVE_GUARD_EN
        exp_g[4] = 32'h10C;
`endif
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("t4_grant%0d", i), g_addr[i], exp_g[i]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
